// File: rtl/piso_shift_reg.sv
// Parallel-in, serial-out shift register with a valid/ready load handshake.
// A WIDTH-bit word is accepted when load_valid && load_ready, then leaves
// on so one bit per clock. so_valid marks data bits and done marks the last
// bit of each word. A new word can be accepted on the edge that retires the
// last bit of the current one, so back-to-back words have no idle gap.
//
// state | meaning
// IDLE  | no word in flight, so/so_valid/done low
// SHIFT | word in flight, cnt = bits remaining after the one on so
module piso_shift_reg #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pi,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             so,
  output logic             so_valid,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sr;
  logic [CW-1:0]    cnt;
  logic             accept;
  logic             first_bit;
  logic             next_bit;
  logic [WIDTH-1:0] sr_shifted;

  // Ready while idle or while the last bit of the current word is on so.
  assign load_ready = (state == IDLE) || (cnt == '0);
  assign accept     = load_valid && load_ready;

  // The bit that leaves first from the incoming word, and the bit that
  // follows the one currently on so.  Vacated positions fill with zero.
  assign first_bit  = MSB_FIRST ? pi[WIDTH-1] : pi[0];
  assign next_bit   = MSB_FIRST ? sr[WIDTH-2] : sr[1];
  assign sr_shifted = MSB_FIRST ? {sr[WIDTH-2:0], 1'b0} : {1'b0, sr[WIDTH-1:1]};

  // Handshake, bit sequencing and registered serial outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      sr       <= '0;
      cnt      <= '0;
      so       <= 1'b0;
      so_valid <= 1'b0;
      done     <= 1'b0;
    end else if (accept) begin
      state    <= SHIFT;
      sr       <= pi;
      cnt      <= CNT_LOAD;
      so       <= first_bit;
      so_valid <= 1'b1;
      done     <= 1'b0;
    end else if (state == SHIFT && cnt != '0) begin
      sr       <= sr_shifted;
      cnt      <= cnt - CNT_ONE;
      so       <= next_bit;
      so_valid <= 1'b1;
      done     <= (cnt == CNT_ONE);
    end else if (state == SHIFT) begin
      // Last bit retired with no follow-on word.
      state    <= IDLE;
      sr       <= '0;
      so       <= 1'b0;
      so_valid <= 1'b0;
      done     <= 1'b0;
    end
  end

endmodule

// File: tb/tb_piso_shift_reg.sv
// Bench for piso_shift_reg: an MSB-first and an LSB-first instance share
// clk/rst/pi/load_valid. Each is compared every cycle against a queue of
// bits still to be transmitted; a behavioural SIPO on the MSB-first so
// checks the loopback word.
module tb_piso_shift_reg;

  logic       clk;
  logic       rst;
  logic [3:0] pi;
  logic       load_valid;
  logic       ready_m, so_m, so_valid_m, done_m;
  logic       ready_l, so_l, so_valid_l, done_l;

  int compared;
  int mismatched;

  bit         q_m[$];
  bit         q_l[$];
  logic [3:0] wq[$];
  logic [3:0] sipo_po;

  piso_shift_reg #(.WIDTH(4), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .pi(pi), .load_valid(load_valid),
    .load_ready(ready_m), .so(so_m), .so_valid(so_valid_m), .done(done_m)
  );

  piso_shift_reg #(.WIDTH(4), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .pi(pi), .load_valid(load_valid),
    .load_ready(ready_l), .so(so_l), .so_valid(so_valid_l), .done(done_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Receiving 4-bit SIPO fed by the MSB-first serial output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sipo_po <= 4'b0000;
    else     sipo_po <= {sipo_po[2:0], so_m};
  end

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ":msb.so"},       {3'b0, so_m},       {3'b0, (q_m.size() > 0) ? q_m[0] : 1'b0});
    chk({tag, ":msb.so_valid"}, {3'b0, so_valid_m}, {3'b0, q_m.size() > 0});
    chk({tag, ":msb.done"},     {3'b0, done_m},     {3'b0, q_m.size() == 1});
    chk({tag, ":msb.ready"},    {3'b0, ready_m},    {3'b0, q_m.size() <= 1});
    chk({tag, ":lsb.so"},       {3'b0, so_l},       {3'b0, (q_l.size() > 0) ? q_l[0] : 1'b0});
    chk({tag, ":lsb.so_valid"}, {3'b0, so_valid_l}, {3'b0, q_l.size() > 0});
    chk({tag, ":lsb.done"},     {3'b0, done_l},     {3'b0, q_l.size() == 1});
    chk({tag, ":lsb.ready"},    {3'b0, ready_l},    {3'b0, q_l.size() <= 1});
  endtask

  task automatic clear_model();
    q_m.delete();
    q_l.delete();
    wq.delete();
  endtask

  // One clock: present inputs, advance the reference across the edge, check.
  task automatic cycle(input string tag, input logic lv, input logic [3:0] p);
    bit acc_m, acc_l, last_m;
    load_valid = lv;
    pi         = p;
    acc_m  = lv && (q_m.size() <= 1);
    acc_l  = lv && (q_l.size() <= 1);
    last_m = (q_m.size() == 1);
    @(posedge clk);
    #1;
    if (q_m.size() > 0) void'(q_m.pop_front());
    if (q_l.size() > 0) void'(q_l.pop_front());
    if (last_m && wq.size() > 0) chk({tag, ":loopback.po"}, sipo_po, wq.pop_front());
    if (acc_m) begin
      for (int i = 3; i >= 0; i--) q_m.push_back(p[i]);
      wq.push_back(p);
    end
    if (acc_l) begin
      for (int i = 0; i <= 3; i++) q_l.push_back(p[i]);
    end
    check_all(tag);
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    rst        = 1'b1;
    load_valid = 1'b0;
    pi         = 4'b0000;
    clear_model();

    // Reset held for three clocks with random inputs.
    for (int i = 0; i < 3; i++) begin
      pi         = 4'($urandom);
      load_valid = 1'($urandom);
      @(posedge clk);
      #1;
      check_all("reset");
    end
    rst        = 1'b0;
    load_valid = 1'b0;

    // Single word 1011, one-cycle load_valid, then idle.
    cycle("single", 1'b1, 4'b1011);
    for (int i = 0; i < 5; i++) cycle("single", 1'b0, 4'($urandom));

    // Back-to-back 1011 then 0110 with load_valid held.
    cycle("b2b", 1'b1, 4'b1011);
    cycle("b2b", 1'b1, 4'b0110);
    cycle("b2b", 1'b1, 4'b0110);
    cycle("b2b", 1'b1, 4'b0110);
    cycle("b2b", 1'b1, 4'b0110);
    for (int i = 0; i < 5; i++) cycle("b2b", 1'b0, 4'b0000);

    // Load pulse while busy is ignored.
    cycle("busy", 1'b1, 4'b1100);
    cycle("busy", 1'b1, 4'b0011);
    for (int i = 0; i < 5; i++) cycle("busy", 1'b0, 4'b0011);

    // Async reset between edges while bit 2 is on so.
    cycle("midrst", 1'b1, 4'b1110);
    cycle("midrst", 1'b0, 4'b0000);
    cycle("midrst", 1'b0, 4'b0000);
    #3;
    rst = 1'b1;
    #1;
    clear_model();
    check_all("midrst.async");
    @(posedge clk);
    #1;
    check_all("midrst.held");
    rst = 1'b0;
    cycle("after_rst", 1'b1, 4'b0101);
    for (int i = 0; i < 5; i++) cycle("after_rst", 1'b0, 4'b0000);

    // LSB-first word 0001 (MSB instance sends it too).
    cycle("lsb", 1'b1, 4'b0001);
    for (int i = 0; i < 5; i++) cycle("lsb", 1'b0, 4'b0000);

    // Random traffic, including loads while busy and pi changes in flight.
    for (int i = 0; i < 300; i++) begin
      cycle("random", 1'($urandom_range(0, 3) != 0), 4'($urandom));
    end
    for (int i = 0; i < 6; i++) cycle("drain", 1'b0, 4'b0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
